fsm_seq_detect_mc: RTL and testbench
====================================

# fsm_seq_detect_mc

Multi-channel, parametrised serial sequence detector: CH independent six-state Moore/Mealy FSMs, each consuming one qualified input bit per valid cycle. Each channel produces a sticky level flag `y`, a one-cycle event code `x`, and a saturating event counter. The block sits behind the serial front-end and replaces the single-channel, always-advancing detector. It adds per-channel input stall, configurable code/counter widths and a software counter clear.

## Interface
- `CH`, 4: number of independent channels (≥1)
- `XW`, 8: event code width (≥2)
- `CNTW`, 16: per-channel event counter width (≥1)
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `i`  in  CH  serial data bit per channel
- `i_vld`  in  CH  channel c advances only when `i_vld[c]`=1
- `cnt_clr`  in  1  synchronous clear of all event counters
- `y`  out  CH  per-channel level flag
- `x`  out  CH*XW  per-channel event code, channel c at bits [c*XW +: XW]
- `evt_cnt`  out  CH*CNTW  per-channel saturating count of nonzero `x`
- `st`  out  CH*3  per-channel current state, for debug

## Operation
- States per channel: S0=0 … S5=1…5; 3-bit encoding; codes 6 and 7 are illegal.
- Transitions are taken only when `i_vld[c]`=1; otherwise the state holds:
  - S0: i=1→S1, i=0→S0
  - S1: i=1→S2, i=0→S3
  - S2: i=1→S0, i=0→S4
  - S3: →S1, unconditional (still needs vld)
  - S4: i=0→S5, i=1→S3
  - S5: i=0→S0, i=1→S2
  - Illegal code: →S0 on the next cycle regardless of vld.
- `y[c]`, registered, evaluated every cycle:
  - set when state==S2
  - cleared when state==S5
  - otherwise held
- `x[c]`, registered, zero by default each cycle:
  - XW'd1 when a taken transition is S1→S2
  - XW'd2 when a taken transition is S4→S3
  - all other cycles 0
- `evt_cnt[c]`:
  - increments by 1 in the cycle `x[c]` is driven nonzero
  - saturates at 2^CNTW−1 and does not wrap
- `cnt_clr`:
  - zeroes all counters
  - wins over a simultaneous increment, so the result is 0
  - does not affect state, `y` or `x`
- Channels are fully independent; no shared arbitration.

## Timing
- Reset (rst_n=0 at a clk edge) sets:
  - all states to S0
  - `y`=0, `x`=0, `evt_cnt`=0
- Reset has priority over every other input. Asserting it mid-sequence aborts the sequence with no `x` pulse.
- Latency:
  - A transition sampled at edge k appears on `st` after edge k.
  - The matching `x` pulse appears in the same cycle as the new `st` and lasts exactly one cycle.
  - `evt_cnt` reflects that pulse one cycle later.
- `y` lags state by one cycle:
  - Entering S2 at edge k sets `y` at edge k+1.
  - Entering S5 at edge k clears `y` at edge k+1.
- With `i_vld` low, `x` returns to 0 after one cycle and state and `y` hold. There is no back-pressure output.
- Throughput: one bit per channel per cycle.

## Structure
- Package `fsm_seq_pkg`:
  - state localparams S0..S5 and state width 3
  - event codes EVT_NONE=0, EVT_A=1 (S1→S2), EVT_B=2 (S4→S3)
- Sub-module `fsm_seq_chan`: one channel (state reg, next-state logic, `y`, `x`, counter), parametrised by XW and CNTW.
- Top level: generate loop of CH instances plus output packing.

## Test plan
- Reset: hold rst_n=0 three cycles with random `i`/`i_vld` → `st`=0, `y`=0, `x`=0, `evt_cnt`=0 on all channels.
- Channel 0 with vld=1, bits 1,1,0,0,1 → states S1,S2,S4,S5,S2. Then:
  - `x0`=1 exactly once (with S2)
  - `y0`: 1 after S2, 0 after S5, 1 again
  - `evt_cnt0`=1
- Stall: channel 1 bits 1,1 with `i_vld` gaps of 3 cycles between them → state holds in S1 during the gaps, `x1`=1 only once, on the S1→S2 step.
- Channel independence with CH=4: channel 2 runs S1,S2,S4,S3 (bits 1,1,0,1) → `x2`=2 then 1 later. Channels 0, 1 and 3 stay idle at S0 with `x`=0.
- Saturation and clear with CNTW=2: generate 5 events → `evt_cnt`=3. Then `cnt_clr` coincident with a 6th event → 0.
- Illegal state forced to 7 via force/release → S0 next cycle with vld=0, no `x` pulse. Also assert rst_n=0 mid-sequence at S4 → S0 with no `x` pulse.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the multi-channel sequence detector:
// state encoding and event codes.
package fsm_seq_pkg;

    localparam int STW = 3;

    typedef enum logic [STW-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_t;

    localparam int EVT_NONE = 0;
    localparam int EVT_A    = 1;
    localparam int EVT_B    = 2;

endpackage

// File: rtl/fsm_seq_chan.sv
// One detector channel: six-state FSM that advances on valid bits,
// plus sticky flag y, one-cycle event code x and a saturating event counter.
module fsm_seq_chan
    import fsm_seq_pkg::*;
#(
    parameter int XW   = 8,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i,
    input  logic            i_vld,
    input  logic            cnt_clr,
    output logic            y,
    output logic [XW-1:0]   x,
    output logic [CNTW-1:0] evt_cnt,
    output logic [STW-1:0]  st
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    state_t          state;
    state_t          state_nxt;
    logic [XW-1:0]   evt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S0;
            x     <= '0;
            y     <= 1'b0;
        end else begin
            state <= state_nxt;
            x     <= evt_nxt;
            // y follows the state being left, so it lags st by one cycle
            if (state == S2) begin
                y <= 1'b1;
            end else if (state == S5) begin
                y <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        evt_nxt   = XW'(EVT_NONE);
        case (state)
            S0: if (i_vld) state_nxt = i ? S1 : S0;
            S1: begin
                if (i_vld) begin
                    if (i) begin
                        state_nxt = S2;
                        evt_nxt   = XW'(EVT_A);
                    end else begin
                        state_nxt = S3;
                    end
                end
            end
            S2: if (i_vld) state_nxt = i ? S0 : S4;
            S3: if (i_vld) state_nxt = S1;
            S4: begin
                if (i_vld) begin
                    if (i) begin
                        state_nxt = S3;
                        evt_nxt   = XW'(EVT_B);
                    end else begin
                        state_nxt = S5;
                    end
                end
            end
            S5: if (i_vld) state_nxt = i ? S2 : S0;
            // illegal encodings recover without waiting for a valid bit
            default: state_nxt = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_cnt <= '0;
        end else if (cnt_clr) begin
            evt_cnt <= '0;
        end else if ((x != '0) && (evt_cnt != CNT_MAX)) begin
            evt_cnt <= evt_cnt + CNTW'(1);
        end
    end

    assign st = state;

endmodule

// File: rtl/fsm_seq_detect_mc.sv
// Multi-channel serial sequence detector: CH independent channels,
// outputs packed channel-major (channel c in the c-th slice).
module fsm_seq_detect_mc
    import fsm_seq_pkg::*;
#(
    parameter int CH   = 4,
    parameter int XW   = 8,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       i,
    input  logic [CH-1:0]       i_vld,
    input  logic                cnt_clr,
    output logic [CH-1:0]       y,
    output logic [CH*XW-1:0]    x,
    output logic [CH*CNTW-1:0]  evt_cnt,
    output logic [CH*STW-1:0]   st
);

    for (genvar c = 0; c < CH; c++) begin : gen_chan
        fsm_seq_chan #(
            .XW   (XW),
            .CNTW (CNTW)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .i       (i[c]),
            .i_vld   (i_vld[c]),
            .cnt_clr (cnt_clr),
            .y       (y[c]),
            .x       (x[c*XW +: XW]),
            .evt_cnt (evt_cnt[c*CNTW +: CNTW]),
            .st      (st[c*STW +: STW])
        );
    end

endmodule

// File: tb/tb_fsm_seq_detect_mc.sv
// Self-checking bench for fsm_seq_detect_mc: vector table plus directed
// sequences for stall, saturation/clear, illegal-state recovery and mid-sequence reset.
module tb_fsm_seq_detect_mc;
    import fsm_seq_pkg::*;

    localparam int CH   = 4;
    localparam int XW   = 8;
    localparam int CNTW = 2;

    logic                clk;
    logic                rst_n;
    logic [CH-1:0]       i;
    logic [CH-1:0]       i_vld;
    logic                cnt_clr;
    logic [CH-1:0]       y;
    logic [CH*XW-1:0]    x;
    logic [CH*CNTW-1:0]  evt_cnt;
    logic [CH*STW-1:0]   st;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst_n;
        logic [3:0]  i;
        logic [3:0]  vld;
        logic        clr;
        logic [11:0] st;
        logic [3:0]  y;
        logic [31:0] x;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    fsm_seq_detect_mc #(
        .CH   (CH),
        .XW   (XW),
        .CNTW (CNTW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i       (i),
        .i_vld   (i_vld),
        .cnt_clr (cnt_clr),
        .y       (y),
        .x       (x),
        .evt_cnt (evt_cnt),
        .st      (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] sts(input int s3, input int s2, input int s1, input int s0);
        return {s3[2:0], s2[2:0], s1[2:0], s0[2:0]};
    endfunction

    function automatic logic [31:0] xs(input int x3, input int x2, input int x1, input int x0);
        return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
    endfunction

    function automatic logic [7:0] cs(input int c3, input int c2, input int c1, input int c0);
        return {c3[1:0], c2[1:0], c1[1:0], c0[1:0]};
    endfunction

    function automatic void add_vec(input logic r, input logic [3:0] iv, input logic [3:0] vv,
                                    input logic c, input logic [11:0] s, input logic [3:0] yy,
                                    input logic [31:0] xx, input logic [7:0] cc);
        vec_t v;
        v.rst_n = r;
        v.i     = iv;
        v.vld   = vv;
        v.clr   = c;
        v.st    = s;
        v.y     = yy;
        v.x     = xx;
        v.cnt   = cc;
        vecs.push_back(v);
    endfunction

    // inputs change on the falling edge; outputs are sampled 1 ns after the rising edge
    task automatic apply_stimulus(input logic r, input logic [3:0] iv, input logic [3:0] vv,
                                  input logic c);
        @(negedge clk);
        rst_n   = r;
        i       = iv;
        i_vld   = vv;
        cnt_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [2:0] st_of(input int c);
        return st[c*STW +: STW];
    endfunction

    function automatic logic [7:0] x_of(input int c);
        return x[c*XW +: XW];
    endfunction

    function automatic logic [1:0] cnt_of(input int c);
        return evt_cnt[c*CNTW +: CNTW];
    endfunction

    initial begin
        rst_n   = 1'b0;
        i       = '0;
        i_vld   = '0;
        cnt_clr = 1'b0;

        // channel 0: bits 1,1,0,0,1
        add_vec(1, 4'b0001, 4'b0001, 0, sts(0,0,0,1), 4'b0000, xs(0,0,0,0), cs(0,0,0,0));
        add_vec(1, 4'b0001, 4'b0001, 0, sts(0,0,0,2), 4'b0000, xs(0,0,0,1), cs(0,0,0,0));
        add_vec(1, 4'b0000, 4'b0001, 0, sts(0,0,0,4), 4'b0001, xs(0,0,0,0), cs(0,0,0,1));
        add_vec(1, 4'b0000, 4'b0001, 0, sts(0,0,0,5), 4'b0001, xs(0,0,0,0), cs(0,0,0,1));
        add_vec(1, 4'b0001, 4'b0001, 0, sts(0,0,0,2), 4'b0000, xs(0,0,0,0), cs(0,0,0,1));
        add_vec(1, 4'b0000, 4'b0000, 0, sts(0,0,0,2), 4'b0001, xs(0,0,0,0), cs(0,0,0,1));
        // channel 1: bit 1, three stalled cycles, bit 1
        add_vec(1, 4'b0010, 4'b0010, 0, sts(0,0,1,2), 4'b0001, xs(0,0,0,0), cs(0,0,0,1));
        add_vec(1, 4'b1111, 4'b0000, 0, sts(0,0,1,2), 4'b0001, xs(0,0,0,0), cs(0,0,0,1));
        add_vec(1, 4'b1111, 4'b0000, 0, sts(0,0,1,2), 4'b0001, xs(0,0,0,0), cs(0,0,0,1));
        add_vec(1, 4'b1111, 4'b0000, 0, sts(0,0,1,2), 4'b0001, xs(0,0,0,0), cs(0,0,0,1));
        add_vec(1, 4'b0010, 4'b0010, 0, sts(0,0,2,2), 4'b0001, xs(0,0,1,0), cs(0,0,0,1));
        add_vec(1, 4'b0000, 4'b0000, 0, sts(0,0,2,2), 4'b0011, xs(0,0,0,0), cs(0,0,1,1));
        add_vec(1, 4'b0000, 4'b0000, 0, sts(0,0,2,2), 4'b0011, xs(0,0,0,0), cs(0,0,1,1));
        // reset overrides all active inputs
        add_vec(0, 4'b1111, 4'b1111, 1, sts(0,0,0,0), 4'b0000, xs(0,0,0,0), cs(0,0,0,0));
        // channel 2: bits 1,1,0,1 then 1,1 while the others idle
        add_vec(1, 4'b0100, 4'b0100, 0, sts(0,1,0,0), 4'b0000, xs(0,0,0,0), cs(0,0,0,0));
        add_vec(1, 4'b0100, 4'b0100, 0, sts(0,2,0,0), 4'b0000, xs(0,1,0,0), cs(0,0,0,0));
        add_vec(1, 4'b0000, 4'b0100, 0, sts(0,4,0,0), 4'b0100, xs(0,0,0,0), cs(0,1,0,0));
        add_vec(1, 4'b0100, 4'b0100, 0, sts(0,3,0,0), 4'b0100, xs(0,2,0,0), cs(0,1,0,0));
        add_vec(1, 4'b0000, 4'b0000, 0, sts(0,3,0,0), 4'b0100, xs(0,0,0,0), cs(0,2,0,0));
        add_vec(1, 4'b0100, 4'b0100, 0, sts(0,1,0,0), 4'b0100, xs(0,0,0,0), cs(0,2,0,0));
        add_vec(1, 4'b0100, 4'b0100, 0, sts(0,2,0,0), 4'b0100, xs(0,1,0,0), cs(0,2,0,0));
        add_vec(1, 4'b0000, 4'b0000, 0, sts(0,2,0,0), 4'b0100, xs(0,0,0,0), cs(0,3,0,0));
        // clear alone leaves state and y untouched
        add_vec(1, 4'b0000, 4'b0000, 1, sts(0,2,0,0), 4'b0100, xs(0,0,0,0), cs(0,0,0,0));

        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)));
            check_output($sformatf("reset%0d.st", k), 64'(st), 64'(0));
            check_output($sformatf("reset%0d.y", k), 64'(y), 64'(0));
            check_output($sformatf("reset%0d.x", k), 64'(x), 64'(0));
            check_output($sformatf("reset%0d.cnt", k), 64'(evt_cnt), 64'(0));
        end

        for (int n = 0; n < vecs.size(); n++) begin
            apply_stimulus(vecs[n].rst_n, vecs[n].i, vecs[n].vld, vecs[n].clr);
            check_output($sformatf("vec%0d.st", n), 64'(st), 64'(vecs[n].st));
            check_output($sformatf("vec%0d.y", n), 64'(y), 64'(vecs[n].y));
            check_output($sformatf("vec%0d.x", n), 64'(x), 64'(vecs[n].x));
            check_output($sformatf("vec%0d.cnt", n), 64'(evt_cnt), 64'(vecs[n].cnt));
        end

        // channel 3: five S0->S1->S2->S0 loops, counter saturates at 3
        for (int e = 1; e <= 5; e++) begin
            apply_stimulus(1'b1, 4'b1000, 4'b1000, 1'b0);
            check_output($sformatf("sat%0d.st_a", e), 64'(st_of(3)), 64'(1));
            apply_stimulus(1'b1, 4'b1000, 4'b1000, 1'b0);
            check_output($sformatf("sat%0d.x", e), 64'(x_of(3)), 64'(1));
            apply_stimulus(1'b1, 4'b1000, 4'b1000, 1'b0);
            check_output($sformatf("sat%0d.st_c", e), 64'(st_of(3)), 64'(0));
            check_output($sformatf("sat%0d.cnt", e), 64'(cnt_of(3)), 64'((e < 3) ? e : 3));
        end

        // sixth event with clear on the incrementing edge
        apply_stimulus(1'b1, 4'b1000, 4'b1000, 1'b0);
        apply_stimulus(1'b1, 4'b1000, 4'b1000, 1'b0);
        check_output("clr1.x", 64'(x_of(3)), 64'(1));
        apply_stimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
        check_output("clr1.cnt", 64'(cnt_of(3)), 64'(0));
        check_output("clr1.st", 64'(st_of(3)), 64'(2));

        // same race from a non-saturated counter
        apply_stimulus(1'b1, 4'b1000, 4'b1000, 1'b0);
        apply_stimulus(1'b1, 4'b1000, 4'b1000, 1'b0);
        apply_stimulus(1'b1, 4'b1000, 4'b1000, 1'b0);
        check_output("clr2.x", 64'(x_of(3)), 64'(1));
        check_output("clr2.cnt_before", 64'(cnt_of(3)), 64'(0));
        apply_stimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
        check_output("clr2.cnt", 64'(cnt_of(3)), 64'(0));
        check_output("clr2.y", 64'(y[3]), 64'(1));
        check_output("clr2.st", 64'(st_of(3)), 64'(2));

        // illegal code 7 on channel 0 returns to S0 with no valid bit
        @(negedge clk);
        rst_n   = 1'b1;
        i       = '0;
        i_vld   = '0;
        cnt_clr = 1'b0;
        force dut.gen_chan[0].u_chan.state = state_t'(3'd7);
        #1;
        release dut.gen_chan[0].u_chan.state;
        @(posedge clk);
        #1;
        check_output("illegal.st", 64'(st_of(0)), 64'(0));
        check_output("illegal.x", 64'(x_of(0)), 64'(0));

        // channel 1 to S4, then reset on the edge that would have produced EVT_B
        apply_stimulus(1'b1, 4'b0010, 4'b0010, 1'b0);
        apply_stimulus(1'b1, 4'b0010, 4'b0010, 1'b0);
        check_output("midrst.x_a", 64'(x_of(1)), 64'(1));
        apply_stimulus(1'b1, 4'b0000, 4'b0010, 1'b0);
        check_output("midrst.st_s4", 64'(st_of(1)), 64'(4));
        check_output("midrst.y_set", 64'(y[1]), 64'(1));
        apply_stimulus(1'b0, 4'b0010, 4'b0010, 1'b0);
        check_output("midrst.st", 64'(st_of(1)), 64'(0));
        check_output("midrst.x", 64'(x_of(1)), 64'(0));
        check_output("midrst.y", 64'(y[1]), 64'(0));
        check_output("midrst.cnt", 64'(cnt_of(1)), 64'(0));
        apply_stimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        check_output("midrst.x_after", 64'(x), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
